// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one shared memory port
// One transaction in flight; data wins ties unless fetch has waited STARVE_MAX grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        stall_f,
  output logic        stall_m
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  state_t      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_valid_q, i_valid_d;
  logic        d_valid_q, d_valid_d;
  logic        i_live, d_live;

  // A port whose completion is being reported this cycle does not compete.
  assign i_live = i_req & ~i_valid_q;
  assign d_live = d_req & ~d_valid_q;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_live && !(i_live && starve_q == SMAX)) begin
          state_d  = DGNT;
          addr_d   = d_addr;
          we_d     = d_we;
          wdata_d  = d_wdata;
          if (!i_live)               starve_d = 3'd0;
          else if (starve_q != SMAX) starve_d = starve_q + 3'd1;
        end else if (i_live) begin
          state_d  = IGNT;
          addr_d   = i_addr;
          we_d     = 1'b0;
          wdata_d  = 32'd0;
          starve_d = 3'd0;
        end
      end
      IGNT: begin
        if (m_ack) begin
          state_d   = IDLE;
          i_valid_d = 1'b1;
          i_rdata_d = m_rdata;
        end
      end
      DGNT: begin
        if (m_ack) begin
          state_d   = IDLE;
          d_valid_d = 1'b1;
          if (!we_q) d_rdata_d = m_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      starve_q  <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign m_req   = (state_q != IDLE);
  assign m_we    = (state_q == DGNT) & we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_valid = i_valid_q;
  assign d_valid = d_valid_q;
  assign stall_f = i_req & ~i_valid_q;
  assign stall_m = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter
module tb_mem_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        stall_f;
  logic        stall_m;

  int total = 0;
  int bad = 0;

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL reset_mreq got=%b exp=0", m_req); end
    total++; if ({i_valid, d_valid, m_we} !== 3'b000) begin bad++; $display("FAIL reset_valid got=%b exp=000", {i_valid, d_valid, m_we}); end
    total++; if ({i_rdata, d_rdata} !== 64'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", {i_rdata, d_rdata}); end
    total++; if ({m_addr, m_wdata} !== 64'd0) begin bad++; $display("FAIL reset_maddr got=%h exp=0", {m_addr, m_wdata}); end
    total++; if ({stall_f, stall_m} !== 2'b00) begin bad++; $display("FAIL reset_stall got=%b exp=00", {stall_f, stall_m}); end
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100;
    #1;
    total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL fetch_stall_pre got=%b exp=1", stall_f); end
    @(negedge clk);
    total++; if (m_req !== 1'b1) begin bad++; $display("FAIL fetch_mreq got=%b exp=1", m_req); end
    total++; if (m_addr !== 32'h100) begin bad++; $display("FAIL fetch_maddr got=%h exp=100", m_addr); end
    total++; if ({m_we, i_valid, stall_f} !== 3'b001) begin bad++; $display("FAIL fetch_wait got=%b exp=001", {m_we, i_valid, stall_f}); end
    @(negedge clk);
    total++; if (m_req !== 1'b1) begin bad++; $display("FAIL fetch_mreq2 got=%b exp=1", m_req); end
    m_ack = 1'b1; m_rdata = 32'hE3A01005;
    @(negedge clk);
    m_ack = 1'b0; m_rdata = 32'h0;
    total++; if (i_valid !== 1'b1) begin bad++; $display("FAIL fetch_valid got=%b exp=1", i_valid); end
    total++; if (i_rdata !== 32'hE3A01005) begin bad++; $display("FAIL fetch_rdata got=%h exp=e3a01005", i_rdata); end
    total++; if ({m_req, stall_f} !== 2'b00) begin bad++; $display("FAIL fetch_done got=%b exp=00", {m_req, stall_f}); end
    i_req = 1'b0;
    @(negedge clk);
    total++; if ({i_valid, m_req} !== 2'b00) begin bad++; $display("FAIL fetch_pulse got=%b exp=00", {i_valid, m_req}); end
    total++; if (i_rdata !== 32'hE3A01005) begin bad++; $display("FAIL fetch_hold got=%h exp=e3a01005", i_rdata); end
  endtask

  task automatic test_simultaneous();
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    @(negedge clk);
    total++; if ({m_req, m_we} !== 2'b10) begin bad++; $display("FAIL simul_dgnt got=%b exp=10", {m_req, m_we}); end
    total++; if (m_addr !== 32'h200) begin bad++; $display("FAIL simul_daddr got=%h exp=200", m_addr); end
    m_ack = 1'b1; m_rdata = 32'h11112222;
    @(negedge clk);
    m_ack = 1'b0;
    total++; if ({d_valid, i_valid} !== 2'b10) begin bad++; $display("FAIL simul_dvalid got=%b exp=10", {d_valid, i_valid}); end
    total++; if (d_rdata !== 32'h11112222) begin bad++; $display("FAIL simul_drdata got=%h exp=11112222", d_rdata); end
    d_req = 1'b0;
    @(negedge clk);
    total++; if (m_req !== 1'b1 || m_addr !== 32'h300) begin bad++; $display("FAIL simul_igrant got=%b/%h exp=1/300", m_req, m_addr); end
    m_ack = 1'b1; m_rdata = 32'h33334444;
    @(negedge clk);
    m_ack = 1'b0;
    total++; if ({i_valid, d_valid} !== 2'b10) begin bad++; $display("FAIL simul_ivalid got=%b exp=10", {i_valid, d_valid}); end
    total++; if (i_rdata !== 32'h33334444) begin bad++; $display("FAIL simul_irdata got=%h exp=33334444", i_rdata); end
    i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if ({m_req, m_we} !== 2'b11) begin bad++; $display("FAIL store_we%0d got=%b exp=11", k, {m_req, m_we}); end
      total++; if (m_wdata !== 32'hDEADBEEF || m_addr !== 32'h40) begin bad++; $display("FAIL store_data%0d got=%h/%h exp=deadbeef/40", k, m_wdata, m_addr); end
      d_addr = $urandom; d_wdata = $urandom;
    end
    m_ack = 1'b1; m_rdata = 32'h99999999;
    @(negedge clk);
    m_ack = 1'b0;
    total++; if (d_valid !== 1'b1) begin bad++; $display("FAIL store_valid got=%b exp=1", d_valid); end
    total++; if (d_rdata !== 32'h11112222) begin bad++; $display("FAIL store_rdata got=%h exp=11112222", d_rdata); end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    @(negedge clk);
    total++; if (m_req !== 1'b1 || m_addr !== 32'h500) begin bad++; $display("FAIL rstmid_grant got=%b/%h exp=1/500", m_req, m_addr); end
    #2 reset = 1'b0;
    #1;
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rstmid_async got=%b exp=0", m_req); end
    m_ack = 1'b1; d_addr = 32'h600;
    @(negedge clk);
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL rstmid_novalid got=%b exp=0", d_valid); end
    reset = 1'b1; m_ack = 1'b0;
    @(negedge clk);
    total++; if (m_req !== 1'b1 || m_addr !== 32'h600) begin bad++; $display("FAIL rstmid_regrant got=%b/%h exp=1/600", m_req, m_addr); end
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL rstmid_novalid2 got=%b exp=0", d_valid); end
    m_ack = 1'b1; m_rdata = 32'h5A5A0001;
    @(negedge clk);
    m_ack = 1'b0;
    total++; if (d_valid !== 1'b1 || d_rdata !== 32'h5A5A0001) begin bad++; $display("FAIL rstmid_done got=%b/%h exp=1/5a5a0001", d_valid, d_rdata); end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  // Transaction-level reference: who owns the port, what was captured at grant time.
  task automatic test_random();
    int owner = 0;
    bit iv = 0, dv = 0, l_we = 0, wi, wd, n_iv, n_dv;
    logic [31:0] l_addr = 0, l_wdata = 0, ir = 32'h0, dr = 32'h5A5A0001;
    int starve = 0, pick;
    for (int cyc = 0; cyc < 600; cyc++) begin
      total++; if (m_req !== (owner != 0)) begin bad++; $display("FAIL rnd_mreq c%0d got=%b exp=%b", cyc, m_req, owner != 0); end
      if (owner != 0) begin
        total++; if (m_addr !== l_addr) begin bad++; $display("FAIL rnd_maddr c%0d got=%h exp=%h", cyc, m_addr, l_addr); end
        total++; if (m_we !== (owner == 2 && l_we)) begin bad++; $display("FAIL rnd_mwe c%0d got=%b exp=%b", cyc, m_we, owner == 2 && l_we); end
        if (owner == 2 && l_we) begin
          total++; if (m_wdata !== l_wdata) begin bad++; $display("FAIL rnd_mwdata c%0d got=%h exp=%h", cyc, m_wdata, l_wdata); end
        end
      end
      total++; if ({i_valid, d_valid} !== {iv, dv}) begin bad++; $display("FAIL rnd_valid c%0d got=%b exp=%b", cyc, {i_valid, d_valid}, {iv, dv}); end
      total++; if (i_rdata !== ir) begin bad++; $display("FAIL rnd_irdata c%0d got=%h exp=%h", cyc, i_rdata, ir); end
      total++; if (d_rdata !== dr) begin bad++; $display("FAIL rnd_drdata c%0d got=%h exp=%h", cyc, d_rdata, dr); end

      if (!i_req) begin i_req = ($urandom % 3 == 0); i_addr = $urandom; end
      else if (iv) begin i_req = $urandom % 2; i_addr = $urandom; end
      else if ($urandom % 4 == 0) i_addr = $urandom;
      if (!d_req || dv) begin
        d_req = (d_req && dv) ? 1'($urandom % 2) : ($urandom % 3 == 0);
        d_we = $urandom % 2; d_addr = $urandom; d_wdata = $urandom;
      end else if ($urandom % 4 == 0) begin d_addr = $urandom; d_wdata = $urandom; end
      m_ack = ($urandom % 3 == 0); m_rdata = $urandom;
      #1;
      total++; if ({stall_f, stall_m} !== {i_req && !iv, d_req && !dv}) begin bad++; $display("FAIL rnd_stall c%0d got=%b exp=%b", cyc, {stall_f, stall_m}, {i_req && !iv, d_req && !dv}); end

      n_iv = 0; n_dv = 0;
      if (owner != 0) begin
        if (m_ack) begin
          if (owner == 1) begin n_iv = 1; ir = m_rdata; end
          else begin n_dv = 1; if (!l_we) dr = m_rdata; end
          owner = 0;
        end
      end else begin
        wi = i_req && !iv; wd = d_req && !dv;
        if (wi && wd) pick = (starve == SM) ? 1 : 2;
        else if (wi) pick = 1;
        else if (wd) pick = 2;
        else pick = 0;
        if (pick == 2) begin
          owner = 2; l_addr = d_addr; l_we = d_we; l_wdata = d_wdata;
          starve = wi ? ((starve < SM) ? starve + 1 : SM) : 0;
        end else if (pick == 1) begin
          owner = 1; l_addr = i_addr; l_we = 0; starve = 0;
        end
      end
      iv = n_iv; dv = n_dv;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
